// File: rtl/pc_seq_pkg.sv
// ============================================================================
// pc_seq_pkg : shared types and constants for the next-PC sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_SEQ    = 3'd0,
      SEL_BRANCH = 3'd1,
      SEL_JUMP   = 3'd2,
      SEL_MRET   = 3'd3,
      SEL_TRAP   = 3'd4
   } pc_sel_t;

   localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] C_TRAP_VECTOR  = 32'h0000_0100;
   localparam int          C_BOOT_CYCLES  = 2;
   localparam logic [31:0] C_PC_INCR      = 32'd4;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_target_mux.sv
// ============================================================================
// pc_target_mux : priority select of the next PC plus misaligned-target check
// Config macro  : PC_SEQ_TRAP_EN (trap / mret / misaligned redirect to trap)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_target_mux
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = C_TRAP_VECTOR
) (
   input  logic [31:0] pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        trap_req,
   input  logic        mret,
   input  logic [31:0] epc,
   output pc_sel_t     sel,
   output logic [31:0] target,
   output logic        misaligned
);

   logic        w_redirect;
   logic [31:0] w_redir_target;

   // Jump outranks branch, so the checked target is the jump's when both fire
   assign w_redirect     = jump | branch_taken;
   assign w_redir_target = jump ? jump_target : branch_target;
   assign misaligned     = w_redirect & is_misaligned(w_redir_target);

`ifdef PC_SEQ_TRAP_EN
   always_comb begin
      sel    = SEL_SEQ;
      target = pc + C_PC_INCR;
      if (trap_req || misaligned) begin
         sel    = SEL_TRAP;
         target = TRAP_VECTOR;
      end else if (mret) begin
         sel    = SEL_MRET;
         target = epc;
      end else if (jump) begin
         sel    = SEL_JUMP;
         target = jump_target;
      end else if (branch_taken) begin
         sel    = SEL_BRANCH;
         target = branch_target;
      end
   end
`else
   logic w_unused_trap;
   assign w_unused_trap = ^{trap_req, mret, epc};

   // Without trap support a misaligned redirect is silently word-aligned
   always_comb begin
      sel    = SEL_SEQ;
      target = pc + C_PC_INCR;
      if (jump) begin
         sel    = SEL_JUMP;
         target = {jump_target[31:2], 2'b00};
      end else if (branch_taken) begin
         sel    = SEL_BRANCH;
         target = {branch_target[31:2], 2'b00};
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : next-PC controller with boot hold, halt/stall and trap return
// Config macro : PC_SEQ_TRAP_EN (enables trap, mret and epc capture)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = C_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = C_TRAP_VECTOR,
   parameter int          BOOT_CYCLES  = C_BOOT_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        trap_req,
   input  logic        mret,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] pcnext,
   output logic        fetch_valid,
   output logic [31:0] epc,
   output logic        misaligned,
   output logic [1:0]  state
);

   localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_boot_cnt;
   pc_sel_t     w_sel;
   logic [31:0] w_target;
   logic [31:0] w_epc;

   pc_target_mux #(
      .TRAP_VECTOR   (TRAP_VECTOR)
   ) u_mux (
      .pc            (pc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .trap_req      (trap_req),
      .mret          (mret),
      .epc           (w_epc),
      .sel           (w_sel),
      .target        (w_target),
      .misaligned    (misaligned)
   );

`ifdef PC_SEQ_TRAP_EN
   logic [31:0] r_epc;

   // epc captures only on a trap taken in an unstalled RUN cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_epc <= '0;
      end else if (r_state == ST_RUN && !stall && w_sel == SEL_TRAP) begin
         r_epc <= pc;
      end
   end

   assign w_epc = r_epc;
`else
   logic w_unused_sel;
   assign w_unused_sel = ^w_sel;
   assign w_epc        = '0;
`endif

   assign epc = w_epc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_boot_cnt <= '0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               if (r_boot_cnt == C_BOOT_LAST) begin
                  r_state    <= ST_RUN;
                  r_boot_cnt <= '0;
               end else begin
                  r_boot_cnt <= r_boot_cnt + 4'd1;
               end
            end
            ST_RUN: begin
               if (halt_req) r_state <= ST_HALT;
            end
            ST_HALT: begin
               if (resume) r_state <= ST_RUN;
            end
            default: r_state <= ST_BOOT;
         endcase
      end
   end

   assign state = r_state;

   // Reset overrides the PC path immediately, not just at the next edge
   always_comb begin
      pcnext      = RESET_VECTOR;
      fetch_valid = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_RUN: begin
               if (stall) begin
                  pcnext = pc;
               end else begin
                  pcnext      = w_target;
                  fetch_valid = 1'b1;
               end
            end
            ST_HALT: pcnext = pc;
            default: pcnext = RESET_VECTOR;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : scoreboard bench for pc_sequencer against a behavioural model
// Config macro    : PC_SEQ_TRAP_EN (model follows the same build option)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;
   localparam int          BC = 2;

   typedef struct {
      logic        rst_n;
      logic [31:0] pc;
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        jump;
      logic [31:0] jt;
      logic        trap;
      logic        mret;
      logic        halt;
      logic        resume;
   } stim_t;

   typedef struct {
      logic [31:0] pcnext;
      logic        fv;
      logic        mis;
      logic [31:0] epc;
      logic [1:0]  state;
      logic        regs_known;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = '0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        trap_req = 1'b0;
   logic        mret = 1'b0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic [31:0] pcnext;
   logic        fetch_valid;
   logic [31:0] epc;
   logic        misaligned;
   logic [1:0]  state;

   pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc            (pc),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .trap_req      (trap_req),
      .mret          (mret),
      .halt_req      (halt_req),
      .resume        (resume),
      .pcnext        (pcnext),
      .fetch_valid   (fetch_valid),
      .epc           (epc),
      .misaligned    (misaligned),
      .state         (state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t exp_q[$];

   // Behavioural model: edges since reset release, a halted flag and saved epc
   bit          m_known = 1'b0;
   int          m_boot_edges = 0;
   bit          m_halted = 1'b0;
   logic [31:0] m_epc = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic bit trap_en();
`ifdef PC_SEQ_TRAP_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic exp_t predict(input stim_t s);
      exp_t        e;
      logic [31:0] tgt;
      bit          redir, in_boot;
      redir   = s.jump || s.br;
      tgt     = s.jump ? s.jt : s.bt;
      in_boot = (m_boot_edges < BC);
      e.mis        = redir && (tgt % 4 != 0);
      e.pcnext     = RV;
      e.fv         = 1'b0;
      e.epc        = trap_en() ? m_epc : 32'd0;
      e.state      = in_boot ? 2'd0 : (m_halted ? 2'd2 : 2'd1);
      e.regs_known = m_known;
      if (s.rst_n && !in_boot) begin
         if (m_halted || s.stall) begin
            e.pcnext = s.pc;
         end else begin
            e.fv = 1'b1;
            if (trap_en() && (s.trap || e.mis)) e.pcnext = TV;
            else if (trap_en() && s.mret)       e.pcnext = m_epc;
            else if (redir)                     e.pcnext = trap_en() ? tgt : tgt - (tgt % 4);
            else                                e.pcnext = s.pc + 32'd4;
         end
      end
      return e;
   endfunction

   function automatic void advance(input stim_t s, input exp_t e);
      if (!s.rst_n) begin
         m_known = 1'b1;
         m_boot_edges = 0;
         m_halted = 1'b0;
         m_epc = '0;
      end else if (m_boot_edges < BC) begin
         m_boot_edges++;
      end else if (m_halted) begin
         if (s.resume) m_halted = 1'b0;
      end else begin
         if (trap_en() && !s.stall && (s.trap || e.mis)) m_epc = s.pc;
         if (s.halt) m_halted = 1'b1;
      end
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      rst_n = s.rst_n; pc = s.pc; stall = s.stall;
      branch_taken = s.br; branch_target = s.bt;
      jump = s.jump; jump_target = s.jt;
      trap_req = s.trap; mret = s.mret; halt_req = s.halt; resume = s.resume;
      e = predict(s);
      exp_q.push_back(e);
      @(posedge clk);
      advance(s, e);
      #1;
   endtask

   function automatic stim_t idle(input logic [31:0] p);
      stim_t s;
      s.rst_n = 1'b1; s.pc = p; s.stall = 1'b0;
      s.br = 1'b0; s.bt = '0; s.jump = 1'b0; s.jt = '0;
      s.trap = 1'b0; s.mret = 1'b0; s.halt = 1'b0; s.resume = 1'b0;
      return s;
   endfunction

   function automatic logic [31:0] rnd_target();
      logic [31:0] t;
      t = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
      return t;
   endfunction

   // Monitor: outputs are stable mid-cycle, so compare on the falling edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("pcnext", pcnext, e.pcnext);
         check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
         check("misaligned", 32'(misaligned), 32'(e.mis));
         if (e.regs_known) begin
            check("state", 32'(state), 32'(e.state));
            check("epc", epc, e.epc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      @(posedge clk); #1;

      s = idle(32'h0); s.rst_n = 1'b0;
      repeat (3) step(s);
      repeat (BC) step(idle(32'h0));
      step(idle(32'h0));

      s = idle(32'h40); s.br = 1'b1; s.bt = 32'h80; s.jump = 1'b1; s.jt = 32'h200;
      step(s);
      s = idle(32'h200); s.br = 1'b1; s.bt = 32'h80;
      step(s);

      s = idle(32'h100); s.jump = 1'b1; s.jt = 32'h202;
      step(s);
      step(idle(32'h100));

      s = idle(32'h44); s.trap = 1'b1;
      step(s);
      step(idle(32'h100));
      s = idle(32'h104); s.mret = 1'b1;
      step(s);
      s = idle(32'h60); s.trap = 1'b1; s.mret = 1'b1;
      step(s);
      step(idle(32'h100));

      s = idle(32'h30); s.stall = 1'b1; s.br = 1'b1; s.bt = 32'h90;
      step(s);
      s = idle(32'h30); s.halt = 1'b1;
      step(s);
      s = idle(32'h34); s.br = 1'b1; s.bt = 32'h90;
      step(s);
      s = idle(32'h34); s.resume = 1'b1; s.halt = 1'b1;
      step(s);
      step(idle(32'h34));

      step(idle(32'hFFFF_FFFC));

      s = idle(32'h10); s.trap = 1'b1; s.halt = 1'b1;
      step(s);
      step(idle(32'h10));
      s = idle(32'h10); s.rst_n = 1'b0;
      step(s);
      step(idle(32'h10));
      repeat (BC) step(idle(32'h0));

      for (int i = 0; i < 400; i++) begin
         s.rst_n  = ($urandom_range(0, 49) != 0);
         s.pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 4095)) << 2;
         s.stall  = ($urandom_range(0, 5) == 0);
         s.br     = ($urandom_range(0, 2) == 0);
         s.bt     = rnd_target();
         s.jump   = ($urandom_range(0, 3) == 0);
         s.jt     = rnd_target();
         s.trap   = ($urandom_range(0, 7) == 0);
         s.mret   = ($urandom_range(0, 5) == 0);
         s.halt   = ($urandom_range(0, 9) == 0);
         s.resume = ($urandom_range(0, 2) == 0);
         step(s);
      end

      @(negedge clk); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-cycle RISC-V core. It drives the `pcnext` input of the program-counter register and chooses among sequential, branch, jump, trap and trap-return targets. It also enforces a post-reset boot hold, stall/halt freezing and misaligned-target handling. The block is combinational on the PC path and sequential for boot, halt and trap-return state.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after boot.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect target for traps.
- `BOOT_CYCLES`, default 2: rising edges held in BOOT after reset release; legal range 1..15.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pc`  in  32  current PC from the PC register.
- `stall`  in  1  freeze PC this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  JAL/JALR.
- `jump_target`  in  32  jump destination.
- `trap_req`  in  1  synchronous exception/ecall.
- `mret`  in  1  return from trap.
- `halt_req`  in  1  enter HALT (ebreak/debug).
- `resume`  in  1  leave HALT.
- `pcnext`  out  32  next PC, combinational.
- `fetch_valid`  out  1  current fetch is architecturally valid.
- `epc`  out  32  saved trap PC, registered.
- `misaligned`  out  1  selected redirect target has bits[1:0] != 0, combinational.
- `state`  out  2  FSM state (BOOT=0, RUN=1, HALT=2).

## Operation
- FSM BOOT→RUN after `BOOT_CYCLES` edges (4-bit counter). In RUN, `halt_req`→HALT. In HALT, `resume`→RUN.
- rst_n low: state, counter and epc are all cleared on the next edge. While rst_n is low, `pcnext`=RESET_VECTOR and `fetch_valid`=0 regardless of state.
- BOOT: `pcnext`=RESET_VECTOR; `fetch_valid`=0; all other inputs are ignored.
- HALT: `pcnext`=`pc`; `fetch_valid`=0; redirects are ignored. `resume` has priority over `halt_req` when both are asserted.
- RUN with `stall`=1: `pcnext`=`pc`; `fetch_valid`=0; all redirect inputs are ignored, so requesters hold them until stall drops. `halt_req` is still honoured.
- RUN with no stall, priority order, highest first:
  - `trap_req`: TRAP_VECTOR.
  - misaligned taken target: TRAP_VECTOR.
  - `mret`: `epc`.
  - `jump`: `jump_target`.
  - `branch_taken`: `branch_target`.
  - otherwise: `pc`+4.
- Misaligned check applies only to the selected jump/branch target; `pc`+4 and `epc` are never checked.
- When a trap fires (trap_req or misaligned), `epc` <= `pc` on that edge. A trap and `mret` in the same cycle: the trap wins, and epc is overwritten.
- `pc`+4 is 32-bit modular arithmetic: 32'hFFFF_FFFC → 32'h0000_0000.
- `halt_req` in the same cycle as a redirect: the redirect is applied on this edge, and the FSM enters HALT at the same edge.

## Timing
- `pcnext`, `fetch_valid` and `misaligned` are zero-latency combinational outputs; the PC register captures `pcnext` at the next rising edge.
- `epc` and `state` update on the rising edge.
- First fetch of RESET_VECTOR with `fetch_valid`=1 occurs in the cycle after BOOT_CYCLES edges with rst_n high. With default 2, this is the 3rd cycle after release.
- Reset mid-operation: the next edge returns the FSM to BOOT, clears epc and clears the counter. A pending halt or trap is discarded.
- Reset values: state=BOOT, epc=0, `fetch_valid`=0, `pcnext`=RESET_VECTOR.

## Configuration
- `PC_SEQ_TRAP_EN` defined: trap, misaligned-redirect, `mret` and `epc` behave as described above.
- `PC_SEQ_TRAP_EN` undefined:
  - `trap_req` and `mret` are ignored.
  - `epc` is tied to 0.
  - Misaligned targets are forced aligned (bits[1:0] cleared) and taken as normal redirects.
  - `misaligned` still reports the condition.

## Structure
- Shared package `pc_seq_pkg` holds:
  - State enum: BOOT, RUN, HALT.
  - PC select enum: SEQ, BRANCH, JUMP, MRET, TRAP.
  - Default vector constants.
  - The PC increment constant, 4.
- One natural sub-module: `pc_target_mux`. It is the purely combinational priority select plus misalignment check, and returns the select code and target. The FSM, counter and epc live in the top.

## Test plan
- Reset held 3 cycles, then released: pcnext=0, fetch_valid=0 for 2 edges; state=RUN, fetch_valid=1 after; pc=0 → pcnext=4.
- RUN, pc=0x40, branch_taken with target 0x80 and jump with target 0x200 in the same cycle → pcnext=0x200. Next cycle, branch only → pcnext=0x80.
- pc=0x100, jump_target=0x202 with TRAP_EN → pcnext=0x100 (TRAP_VECTOR), epc=0x100, misaligned=1. Without TRAP_EN → pcnext=0x200.
- trap_req at pc=0x44 → pcnext=0x100, epc=0x44. Later mret → pcnext=0x44. trap_req+mret together → TRAP_VECTOR, epc updated.
- stall=1 with branch_taken at pc=0x30 → pcnext=0x30, fetch_valid=0. halt_req → HALT, pcnext=pc held. resume → RUN, pcnext=pc+4.
- pc=0xFFFF_FFFC sequential → pcnext=0. rst_n low mid-HALT → state=BOOT, epc=0 next edge.
